// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer and the detector test bench:
// one-hot state codes and the even-parity helper.
package ser_pkg;

    localparam int         ST_W     = 4;
    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_SHIFT = 4'b0010;
    localparam logic [3:0] ST_PAR   = 4'b0100;
    localparam logic [3:0] ST_GAP   = 4'b1000;

    // Even parity over a zero-extended word; the extension bits are 0 and
    // leave the XOR unchanged, so any width up to 32 can be passed in.
    function automatic logic ser_even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/ser_bit_cnt.sv
// Down-counter with load, clear and terminal-count (cnt == 0) flag.
// Used by bit_serializer both for the bits remaining in a word and for the
// inter-word gap countdown.
module ser_bit_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    // Count register: clear beats load beats decrement; holds at zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the sequence-detector chain.
// Accepts WIDTH-bit words on a valid/ready handshake and emits one bit per
// clk on data/data_valid, with optional idle gap between words.
// Optional feature: define SER_PARITY_EN to append an even-parity bit after
// each word (PAR state); frame_done and the back-to-back accept move to it.
//
// state | meaning
// IDLE  | waiting for a word, din_ready=1
// SHIFT | driving payload bits, counter = bits remaining after this one
// PAR   | driving the even-parity bit (SER_PARITY_EN only)
// GAP   | idle-level filler cycles between words
module bit_serializer
    import ser_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             data,
    output logic             data_valid,
    output logic             frame_done,
    output logic             busy
);

`ifdef SER_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif

    // The counter is shared with the gap countdown, so it must also hold
    // GAP_CYCLES-1 (up to 14) even for very narrow words.
    localparam int BIT_W = $clog2(WIDTH);
    localparam int CNT_W = (BIT_W > 4) ? BIT_W : 4;
    localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit B2B = (GAP_CYCLES == 0);

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  state_next;
    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic             cnt_tc;
    logic             cnt_load;
    logic             cnt_clr;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_load_val;
    logic             accept;
    logic             sr_head;
    logic [WIDTH-1:0] sr_shifted;
`ifdef SER_PARITY_EN
    logic             par_q;
`endif

    assign accept     = din_valid && din_ready;
    assign busy       = (state != ST_IDLE);
    assign sr_head    = (MSB_FIRST != 0) ? sr[WIDTH-1] : sr[0];
    assign sr_shifted = (MSB_FIRST != 0) ? (sr << 1) : (sr >> 1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a word accepted on the final cycle restarts SHIFT.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_tc) begin
                    if (PARITY) begin
                        state_next = ST_PAR;
                    end else if (accept) begin
                        state_next = ST_SHIFT;
                    end else if (GAP_CYCLES > 0) begin
                        state_next = ST_GAP;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_PAR: begin
                if (accept) begin
                    state_next = ST_SHIFT;
                end else if (GAP_CYCLES > 0) begin
                    state_next = ST_GAP;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_tc) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake and frame outputs decoded from the registered state.
    always_comb begin
        din_ready  = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: din_ready = 1'b1;
            ST_SHIFT: begin
                if (cnt_tc && !PARITY) begin
                    frame_done = 1'b1;
                    din_ready  = B2B;
                end
            end
            ST_PAR: begin
                frame_done = 1'b1;
                din_ready  = B2B;
            end
            default: begin
                din_ready  = 1'b0;
                frame_done = 1'b0;
            end
        endcase
        if (rst) begin
            din_ready = 1'b0;
        end
    end

    // Counter control: load per word and on gap entry, clear when idle.
    always_comb begin
        cnt_load     = accept || ((state_next == ST_GAP) && (state != ST_GAP));
        cnt_load_val = accept ? LAST_LOAD : GAP_LOAD;
        cnt_dec      = (state == ST_SHIFT) || (state == ST_GAP);
        cnt_clr      = (state_next == ST_IDLE);
    end

    ser_bit_cnt #(
        .CNT_W (CNT_W)
    ) u_bit_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_load_val),
        .cnt      (cnt),
        .tc       (cnt_tc)
    );

    // Shift register and registered serial outputs; the first bit goes
    // straight from din so it appears the cycle after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= '0;
            data       <= IDLE_LEVEL;
            data_valid <= 1'b0;
`ifdef SER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else if (accept) begin
            sr         <= (MSB_FIRST != 0) ? (din << 1) : (din >> 1);
            data       <= (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
            data_valid <= 1'b1;
`ifdef SER_PARITY_EN
            par_q      <= ser_even_parity(32'(din));
`endif
        end else if ((state == ST_SHIFT) && !cnt_tc) begin
            sr         <= sr_shifted;
            data       <= sr_head;
            data_valid <= 1'b1;
        end
`ifdef SER_PARITY_EN
        else if (state == ST_SHIFT) begin
            data       <= par_q;
            data_valid <= 1'b1;
        end
`endif
        else begin
            data       <= IDLE_LEVEL;
            data_valid <= 1'b0;
        end
    end

endmodule
